// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkt_gen
//  Function : AXI-stream style packet source. On an accepted start it emits
//             an incrementing byte pattern (seed, seed+1, ...) with tlast on
//             the final beat, honours m_tready backpressure, then idles for
//             GAP_CYCLES cycles before accepting another request.
//  Revision : 1.0  initial release
// ============================================================================
module axis_pkt_gen #(
  parameter int DATA_W     = 8,
  parameter int MAX_LEN    = 2048,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [11:0]       pkt_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_count
);

  // Gap counter only needs to reach GAP_CYCLES-1; keep at least one bit so
  // the design still elaborates when the gap is disabled.
  localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [11:0]        c_MAX_LEN  = 12'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [11:0]         r_len,       w_len_nxt;
  logic [DATA_W-1:0]   r_seed,      w_seed_nxt;
  logic [11:0]         r_beat_cnt,  w_beat_cnt_nxt;
  logic [c_GAP_W-1:0]  r_gap_cnt,   w_gap_cnt_nxt;
  logic                r_done,      w_done_nxt;
  logic [15:0]         r_pkt_count, w_pkt_count_nxt;

  logic w_send;
  logic w_is_last;
  logic w_hs;

  // Output decode uses registered state only, so m_tvalid never follows m_tready.
  assign w_send    = (r_state == S_SEND);
  assign w_is_last = (r_beat_cnt == (r_len - 12'd1));
  assign w_hs      = w_send && m_tready;

  assign m_tvalid  = w_send;
  assign m_tdata   = w_send ? (r_seed + r_beat_cnt[DATA_W-1:0]) : '0;
  assign m_tlast   = w_send && w_is_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pkt_count = r_pkt_count;

  // Next-state and datapath update; everything holds unless a rule below fires.
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_seed_nxt      = r_seed;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_done_nxt      = 1'b0;
    w_pkt_count_nxt = r_pkt_count;

    case (r_state)
      S_IDLE: begin
        // Zero-length requests are dropped silently.
        if (start && (pkt_len != 12'd0)) begin
          w_len_nxt      = (pkt_len > c_MAX_LEN) ? c_MAX_LEN : pkt_len;
          w_seed_nxt     = seed;
          w_beat_cnt_nxt = 12'd0;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (w_is_last) begin
            w_done_nxt      = 1'b1;
            w_pkt_count_nxt = r_pkt_count + 16'd1;
            w_gap_cnt_nxt   = '0;
            w_state_nxt     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            w_beat_cnt_nxt  = r_beat_cnt + 12'd1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_state_nxt   = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; asynchronous reset clears every output-driving register at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= 12'd0;
      r_seed      <= '0;
      r_beat_cnt  <= 12'd0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
      r_pkt_count <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_seed      <= w_seed_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_done      <= w_done_nxt;
      r_pkt_count <= w_pkt_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pkt_gen
//  Function : Self-checking bench for axis_pkt_gen. A sink monitor collects
//             accepted beats; a packet-level reference model builds the
//             expected byte/tlast stream from seed and clamped length.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_pkt_gen;

  localparam int MAX_LEN = 2048;
  localparam int GAP     = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] pkt_len;
  logic [7:0]  seed;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int exp_count = 0;

  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  axis_pkt_gen #(.DATA_W(8), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pkt_len   (pkt_len),
    .seed      (seed),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .done      (done),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // Sink monitor: sample mid-cycle, record accepted beats, count done pulses,
  // and require a stalled beat to stay unchanged on the following cycle.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
          failures++;
          $display("FAIL hold_stable: got valid=%b data=%02h last=%b, required valid=1 data=%02h last=%b",
                   m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        rx_data.push_back(m_tdata);
        rx_last.push_back(m_tlast);
      end
      prev_hold = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
      prev_data = m_tdata;
      prev_last = m_tlast;
    end
  end

  // Reference model: a packet is min(len, MAX_LEN) bytes counting up from seed mod 256.
  function automatic void model_add(input logic [7:0] s, input int len);
    int n;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(8'((int'(s) + i) % 256));
      exp_last.push_back(i == n - 1);
    end
  endfunction

  function automatic void clear_q();
    rx_data.delete();
    rx_last.delete();
    exp_data.delete();
    exp_last.delete();
  endfunction

  // Number of positions where received and expected streams differ (size difference counts once).
  function automatic int count_mismatch();
    int n;
    int m;
    n = (rx_data.size() != exp_data.size()) ? 1 : 0;
    m = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
    for (int i = 0; i < m; i++) begin
      if (rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) n++;
    end
    return n;
  endfunction

  // Issue one start pulse and run the sink until the done pulse is seen or the budget expires.
  task automatic drive_packet(input logic [7:0] s, input logic [11:0] len, input int pct,
                              input logic [31:0] pat, input int limit, output int k,
                              output bit to, output logic fv, output logic [7:0] fd,
                              output logic fb);
    int d0;
    d0 = done_cnt;
    k  = 0;
    to = 1'b0;
    fv = 1'b0;
    fd = 8'h00;
    fb = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; seed = s; pkt_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      if (pct < 0) m_tready = (k < 32) ? pat[k] : 1'b1;
      else         m_tready = (int'($urandom_range(0, 99)) < pct);
      @(negedge clk); #1;
      if (k == 0) begin
        fv = m_tvalid; fd = m_tdata; fb = busy;
      end
      if (done_cnt != d0) break;
      if (k >= limit) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    m_tready = 1'b1;
  endtask

  // Wait (bounded) for the generator to return to idle after the gap.
  task automatic finish_gap();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; pkt_len = 12'd0; seed = 8'h00; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({m_tdata, m_tvalid, m_tlast, busy, done, pkt_count} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%02h v=%b l=%b busy=%b done=%b cnt=%0d, required all 0",
               m_tdata, m_tvalid, m_tlast, busy, done, pkt_count);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({m_tvalid, busy, done, pkt_count} !== 19'd0) begin
      failures++;
      $display("FAIL after_release: got v=%b busy=%b done=%b cnt=%0d, required all 0",
               m_tvalid, busy, done, pkt_count);
    end
    exp_count = 0;
  endtask

  task automatic test_basic();
    int k; bit to; logic fv; logic [7:0] fd; logic fb; int d0;
    clear_q();
    d0 = done_cnt;
    model_add(8'h10, 4);
    drive_packet(8'h10, 12'd4, 100, 32'h0, 50, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: no done within budget, required done"); end
    checks++;
    if (fv !== 1'b1 || fd !== 8'h10 || fb !== 1'b1) begin
      failures++;
      $display("FAIL basic_first_beat: got v=%b data=%02h busy=%b, required v=1 data=10 busy=1", fv, fd, fb);
    end
    checks++;
    if (k !== 4) begin failures++; $display("FAIL basic_cycles: got %0d, required 4", k); end
    checks++;
    if (count_mismatch() !== 0) begin
      failures++;
      $display("FAIL basic_payload: got %0d mismatches (%0d beats), required 0 (%0d beats)",
               count_mismatch(), rx_data.size(), exp_data.size());
    end
    checks++;
    if (done !== 1'b1 || m_tvalid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_cycle1: got done=%b v=%b busy=%b, required 1 0 1", done, m_tvalid, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || m_tvalid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_cycle2: got done=%b v=%b busy=%b, required 0 0 1", done, m_tvalid, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL gap_end: got busy=%b v=%b, required 0 0", busy, m_tvalid);
    end
    checks++;
    if (done_cnt - d0 !== 1 || pkt_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL basic_count: got done_pulses=%0d cnt=%0d, required 1 and %0d",
               done_cnt - d0, pkt_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    int k; bit to; logic fv; logic [7:0] fd; logic fb;
    clear_q();
    model_add(8'h10, 3);
    drive_packet(8'h10, 12'd3, -1, 32'b101001, 50, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to || k !== 6) begin
      failures++;
      $display("FAIL bp_cycles: got %0d (timeout=%b), required 6", k, to);
    end
    checks++;
    if (count_mismatch() !== 0) begin
      failures++;
      $display("FAIL bp_payload: got %0d mismatches (%0d beats), required 0 (3 beats)",
               count_mismatch(), rx_data.size());
    end
    finish_gap();
  endtask

  task automatic test_boundaries();
    int k; bit to; logic fv; logic [7:0] fd; logic fb; logic [7:0] s; int d0;
    // payload wraps mod 256
    clear_q();
    model_add(8'hFE, 3);
    drive_packet(8'hFE, 12'd3, int'($urandom_range(40, 100)), 32'h0, 200, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to || count_mismatch() !== 0) begin
      failures++;
      $display("FAIL wrap_payload: got %0d mismatches timeout=%b, required 0", count_mismatch(), to);
    end
    finish_gap();
    // single-beat packet
    clear_q();
    s = 8'($urandom);
    model_add(s, 1);
    drive_packet(s, 12'd1, 100, 32'h0, 50, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to || k !== 1 || count_mismatch() !== 0) begin
      failures++;
      $display("FAIL len1: got cycles=%0d mismatches=%0d timeout=%b, required 1 0 0", k, count_mismatch(), to);
    end
    finish_gap();
    // zero-length request must be ignored
    clear_q();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; pkt_len = 12'd0; seed = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) k++;
    end
    checks++;
    if (k !== 0 || done_cnt !== d0 || pkt_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL len0: got active_cycles=%0d done_pulses=%0d cnt=%0d, required 0 0 %0d",
               k, done_cnt - d0, pkt_count, exp_count);
    end
    // oversize request clamps
    clear_q();
    s = 8'($urandom);
    model_add(s, 4095);
    drive_packet(s, 12'd4095, 100, 32'h0, 5000, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to || rx_data.size() !== 2048 || k !== 2048) begin
      failures++;
      $display("FAIL maxlen_beats: got %0d beats in %0d cycles timeout=%b, required 2048", rx_data.size(), k, to);
    end
    checks++;
    if (count_mismatch() !== 0) begin
      failures++;
      $display("FAIL maxlen_payload: got %0d mismatches, required 0", count_mismatch());
    end
    finish_gap();
    checks++;
    if (pkt_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL boundary_count: got %0d, required %0d", pkt_count, exp_count);
    end
  endtask

  task automatic test_busy_start();
    int n; int d0;
    clear_q();
    model_add(8'h20, 8);
    m_tready = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; seed = 8'h20; pkt_len = 12'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; seed = 8'h99; pkt_len = 12'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    exp_count++;
    checks++;
    if (done_cnt == d0 || count_mismatch() !== 0) begin
      failures++;
      $display("FAIL busy_start_payload: got %0d mismatches done=%0d, required 0 and 1",
               count_mismatch(), done_cnt - d0);
    end
    // Hold start through the gap; it may only take effect once idle.
    clear_q();
    start = 1'b1; seed = 8'h40; pkt_len = 12'd2;
    @(negedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL gap_start1: got v=%b, required 0", m_tvalid); end
    @(negedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL gap_start2: got v=%b, required 0", m_tvalid); end
    @(negedge clk); #1;
    start = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h40) begin
      failures++;
      $display("FAIL after_gap_start: got v=%b data=%02h, required v=1 data=40", m_tvalid, m_tdata);
    end
    model_add(8'h40, 2);
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    exp_count++;
    checks++;
    if (count_mismatch() !== 0 || pkt_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL after_gap_pkt: got %0d mismatches cnt=%0d, required 0 and %0d",
               count_mismatch(), pkt_count, exp_count);
    end
    finish_gap();
  endtask

  task automatic test_async_reset();
    int k; bit to; logic fv; logic [7:0] fd; logic fb; logic [7:0] s; int n; int d0; int lasts;
    clear_q();
    s = 8'($urandom);
    d0 = done_cnt;
    m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; seed = s; pkt_len = 12'd10;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (rx_data.size() < 5 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_tdata, m_tvalid, m_tlast, busy, done, pkt_count} !== 28'd0) begin
      failures++;
      $display("FAIL async_reset: got data=%02h v=%b l=%b busy=%b done=%b cnt=%0d, required all 0",
               m_tdata, m_tvalid, m_tlast, busy, done, pkt_count);
    end
    lasts = 0;
    foreach (rx_last[i]) if (rx_last[i] === 1'b1) lasts++;
    checks++;
    if (lasts !== 0 || done_cnt !== d0) begin
      failures++;
      $display("FAIL partial_pkt: got tlast_beats=%0d done_pulses=%0d, required 0 0", lasts, done_cnt - d0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_count = 0;
    clear_q();
    s = 8'($urandom);
    model_add(s, 10);
    drive_packet(s, 12'd10, 100, 32'h0, 50, k, to, fv, fd, fb);
    exp_count++;
    checks++;
    if (to || count_mismatch() !== 0 || pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_pkt: got %0d mismatches cnt=%0d timeout=%b, required 0 1 0",
               count_mismatch(), pkt_count, to);
    end
    finish_gap();
  endtask

  task automatic test_back_to_back();
    int k; bit to; logic fv; logic [7:0] fd; logic fb; logic [7:0] s; int len; int d0; int tos;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_count = 0;
    clear_q();
    d0 = done_cnt;
    tos = 0;
    for (int p = 0; p < 3; p++) begin
      s = 8'($urandom);
      len = int'($urandom_range(1, 64));
      model_add(s, len);
      drive_packet(s, 12'(len), int'($urandom_range(50, 100)), 32'h0, 400, k, to, fv, fd, fb);
      if (to) tos++;
      exp_count++;
      finish_gap();
    end
    checks++;
    if (tos !== 0 || done_cnt - d0 !== 3 || pkt_count !== 16'd3) begin
      failures++;
      $display("FAIL b2b_count: got done_pulses=%0d cnt=%0d timeouts=%0d, required 3 3 0",
               done_cnt - d0, pkt_count, tos);
    end
    checks++;
    if (count_mismatch() !== 0) begin
      failures++;
      $display("FAIL b2b_stream: got %0d mismatches (%0d beats), required 0 (%0d beats)",
               count_mismatch(), rx_data.size(), exp_data.size());
    end
  endtask

  task automatic test_random();
    int k; bit to; logic fv; logic [7:0] fd; logic fb; logic [7:0] s; int len;
    for (int p = 0; p < 8; p++) begin
      clear_q();
      s = 8'($urandom);
      len = int'($urandom_range(1, 200));
      model_add(s, len);
      drive_packet(s, 12'(len), int'($urandom_range(20, 100)), 32'h0, 2000, k, to, fv, fd, fb);
      exp_count++;
      checks++;
      if (to || count_mismatch() !== 0) begin
        failures++;
        $display("FAIL random_pkt%0d: seed=%02h len=%0d got %0d mismatches timeout=%b, required 0",
                 p, s, len, count_mismatch(), to);
      end
      finish_gap();
    end
    checks++;
    if (pkt_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL random_count: got %0d, required %0d", pkt_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_busy_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-stream-style packet transmitter that produces framed byte packets (tdata/tvalid/tready/tlast) on request. Each packet is an incrementing byte pattern, with tlast on the final beat and full honouring of downstream backpressure. It is the source end of the stream FIFO's write interface and is used to drive the FIFO input in system bring-up and loopback testing.

## Interface
Parameters:
- DATA_W, 8, stream data width in bits (only 8 is supported)
- MAX_LEN, 2048, maximum beats per packet; matches the FIFO depth
- GAP_CYCLES, 2, idle cycles with tvalid low after each packet (0 allowed)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request to send one packet; sampled only in IDLE
- pkt_len  in  12  beats in the packet; latched on an accepted start
- seed  in  8  first payload byte; latched on an accepted start
- m_tdata  out  8  payload byte
- m_tvalid  out  1  beat valid
- m_tready  in  1  downstream ready (FIFO input_tready)
- m_tlast  out  1  final beat of the packet
- busy  out  1  high from the first beat through the end of the gap
- done  out  1  one-cycle pulse after the last beat handshake
- pkt_count  out  16  packets completed since reset; wraps at 0xFFFF

## Operation
- States and transitions:
  - IDLE: start with pkt_len != 0 is accepted. Latch len = min(pkt_len, MAX_LEN) and latch seed. Clear beat_cnt and go to SEND.
  - IDLE: start with pkt_len == 0 is ignored. No beats, no done, no count change.
  - SEND: m_tvalid = 1, m_tdata = seed + beat_cnt (mod 256), m_tlast = (beat_cnt == len-1).
  - SEND, handshake (m_tvalid && m_tready at a rising edge), not last beat: beat_cnt increments.
  - SEND, handshake on the last beat: go to GAP, or to IDLE if GAP_CYCLES == 0.
  - GAP: m_tvalid = 0. Count GAP_CYCLES cycles, then go to IDLE.
- Handshake rules:
  - Once m_tvalid rises, m_tvalid, m_tdata and m_tlast stay stable until the handshake.
  - m_tvalid never depends combinationally on m_tready.
- start while busy is ignored; requests are not queued.
- Width rules:
  - beat_cnt is 12 bits; len values above 2048 clamp to 2048.
  - Payload arithmetic is 8-bit modulo; seed 0xFE gives FE, FF, 00, 01, ...
- Outputs are registered or decoded from registered state only; no combinational input-to-output paths.

## Timing
- Reset value of every output is 0: m_tdata, m_tvalid, m_tlast, busy, done, pkt_count.
- Asserting reset_n low mid-packet forces IDLE and clears all outputs immediately, without waiting for a clock. No partial-packet tlast is emitted.
- Latency: start is sampled at edge N. The first beat (m_tvalid = 1, m_tdata = seed) is presented after edge N and can be accepted at edge N+1. busy rises with the first beat.
- Throughput: one beat per cycle while m_tready is held high. With GAP_CYCLES = 0 and start held high, a new packet starts at most two cycles after the previous last handshake (one IDLE cycle).
- Last handshake at edge L:
  - pkt_count increments at L.
  - done is high for exactly one cycle, from L to L+1.
  - With GAP_CYCLES = G > 0, m_tvalid is low for G cycles and busy falls after edge L+G. With G = 0, busy falls at L.
- m_tready low: the current beat is held indefinitely and no counter advances.
- pkt_len = 1: the single beat has m_tlast = 1.

## Test plan
- Basic packet: pkt_len = 4, seed = 0x10, m_tready = 1 -> beats 10, 11, 12, 13 on consecutive cycles; m_tlast only on 13; done pulses once; pkt_count = 1.
- Backpressure: pkt_len = 3, m_tready toggling 1,0,0,1,0,1 -> each beat held stable while m_tready = 0; the sequence 10, 11, 12 is delivered exactly once each, with no duplicate or lost beats.
- Boundaries:
  - seed = 0xFE, pkt_len = 3 -> FE, FF, 00.
  - pkt_len = 1 -> a single beat with tlast.
  - pkt_len = 0 -> no m_tvalid, no done.
  - pkt_len = 4095 -> exactly 2048 beats, tlast on beat 2047.
- Start while busy: pulse start mid-packet with a different seed -> ignored; the current packet completes unchanged. After the GAP_CYCLES = 2 low cycles, the next start is accepted.
- Async reset mid-packet: assert reset_n low at beat 5 of 10 between clock edges -> all outputs 0 immediately. After release, a new start sends a full packet from seed; pkt_count restarts from 0.
- Back-to-back end-to-end: connect to the FIFO and send 3 packets -> 3 done pulses; pkt_count = 3; the FIFO receives all bytes in order with tlast at each packet boundary.
